dadda_mac: RTL and testbench

//  Sequential multiply-accumulate stage built around the combinational 8x8 dadda multiplier.

---
 rtl/dadda_mac.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dadda_mac.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mac.sv
// ---------------------------------------------------------------------------
// dadda_mac
//   Multiply-accumulate stage for a stream of unsigned 8-bit operand pairs.
//   Each accepted pair is registered (S1) and multiplied by a combinational
//   8x8 Dadda tree. The 16-bit product is registered (S2) and then summed
//   into the accumulator (S3). When the beat flagged in_last has been summed,
//   the sum, beat count and sticky overflow are presented downstream. They
//   are held until out_ready completes the handshake.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake; in_a, in_b, in_last sampled on accept
//   out_valid/out_ready result handshake
//   out_acc           sum of products modulo 2^ACC_W
//   out_cnt           beats accumulated, saturating at 2^CNT_W-1
//   out_ovf           sticky carry out of the accumulator's top bit
// ---------------------------------------------------------------------------
module dadda_mac #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);

    typedef enum logic {ST_ACCUM, ST_DONE} state_t;

    // Dadda reduction of the 8x8 partial-product matrix. Each column is held
    // as a packed bit bag plus its height. Every stage compresses columns
    // down to the Dadda limits 6, 4, 3, 2 with the fewest adders, and a
    // final two-row add resolves the product. All heights depend only on
    // constants, so the loops unroll into a fixed adder tree.
    function automatic logic [15:0] dadda_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  col_cur [17];
        logic [7:0]  col_nxt [17];
        int          h_cur [17];
        int          h_nxt [17];
        int          lim;
        int          total;
        int          idx;
        logic [7:0]  rest;
        logic        x;
        logic        y;
        logic        z;
        logic [15:0] row0;
        logic [15:0] row1;

        for (int c = 0; c < 17; c++) begin
            col_cur[5'(c)] = '0;
            h_cur[5'(c)]   = 0;
        end
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                col_cur[5'(i + j)] = col_cur[5'(i + j)]
                                   | (8'(a[3'(j)] & b[3'(i)]) << h_cur[5'(i + j)]);
                h_cur[5'(i + j)] += 1;
            end
        end

        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       lim = 6;
                1:       lim = 4;
                2:       lim = 3;
                default: lim = 2;
            endcase
            for (int c = 0; c < 17; c++) begin
                col_nxt[5'(c)] = '0;
                h_nxt[5'(c)]   = 0;
            end
            // Carries already dropped into a column by its right neighbour
            // count toward that column's height before choosing adders.
            for (int c = 0; c < 16; c++) begin
                total = h_cur[5'(c)] + h_nxt[5'(c)];
                idx   = 0;
                for (int k = 0; k < 4; k++) begin
                    if (total > lim) begin
                        rest = col_cur[5'(c)] >> idx;
                        x    = rest[0];
                        y    = rest[1];
                        z    = rest[2];
                        if (total == lim + 1) begin
                            col_nxt[5'(c)]     = col_nxt[5'(c)] | (8'(x ^ y) << h_nxt[5'(c)]);
                            h_nxt[5'(c)]      += 1;
                            col_nxt[5'(c + 1)] = col_nxt[5'(c + 1)] | (8'(x & y) << h_nxt[5'(c + 1)]);
                            h_nxt[5'(c + 1)]  += 1;
                            idx   += 2;
                            total -= 1;
                        end else begin
                            col_nxt[5'(c)]     = col_nxt[5'(c)] | (8'(x ^ y ^ z) << h_nxt[5'(c)]);
                            h_nxt[5'(c)]      += 1;
                            col_nxt[5'(c + 1)] = col_nxt[5'(c + 1)]
                                               | (8'((x & y) | (x & z) | (y & z)) << h_nxt[5'(c + 1)]);
                            h_nxt[5'(c + 1)]  += 1;
                            idx   += 3;
                            total -= 2;
                        end
                    end
                end
                // Bits not consumed by an adder pass straight to the next stage.
                rest            = col_cur[5'(c)] >> idx;
                col_nxt[5'(c)]  = col_nxt[5'(c)] | (rest << h_nxt[5'(c)]);
                h_nxt[5'(c)]   += h_cur[5'(c)] - idx;
            end
            col_cur = col_nxt;
            h_cur   = h_nxt;
        end

        for (int c = 0; c < 16; c++) begin
            row0[4'(c)] = col_cur[5'(c)][0];
            row1[4'(c)] = col_cur[5'(c)][1];
        end
        return row0 + row1;
    endfunction

    state_t             state_q, state_d;
    logic               last_pending_q, last_pending_d;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic               v1_q, v1_d, last1_q, last1_d;
    logic [15:0]        prod_q, prod_d;
    logic               v2_q, v2_d, last2_q, last2_d;
    logic               v3_q, v3_d, last3_q, last3_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_ovf_q, out_ovf_d;
    logic               accept;
    logic [ACC_W:0]     acc_sum;

    // in_ready is also gated by rst so it reads low while reset is held.
    assign in_ready  = (state_q == ST_ACCUM) && !last_pending_q && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_cnt   = out_cnt_q;
    assign out_ovf   = out_ovf_q;

    // Pipeline advance, accumulation and result FSM next-state logic.
    always_comb begin
        state_d        = state_q;
        last_pending_d = last_pending_q;
        a_d            = a_q;
        b_d            = b_q;
        v1_d           = accept;
        last1_d        = accept && in_last;
        prod_d         = prod_q;
        v2_d           = v1_q;
        last2_d        = v1_q && last1_q;
        v3_d           = v2_q;
        last3_d        = v2_q && last2_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid_q;
        out_acc_d      = out_acc_q;
        out_cnt_d      = out_cnt_q;
        out_ovf_d      = out_ovf_q;
        acc_sum        = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, prod_q};

        if (accept) begin
            a_d = in_a;
            b_d = in_b;
            if (in_last) begin
                last_pending_d = 1'b1;
            end
        end

        if (v1_q) begin
            prod_d = dadda_mul(a_q, b_q);
        end

        if (v2_q) begin
            acc_d = acc_sum[ACC_W-1:0];
            ovf_d = ovf_q | acc_sum[ACC_W];
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_ACCUM: begin
                if (v3_q && last3_q) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_acc_d   = acc_q;
                    out_cnt_d   = cnt_q;
                    out_ovf_d   = ovf_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d        = ST_ACCUM;
                    out_valid_d    = 1'b0;
                    acc_d          = '0;
                    cnt_d          = '0;
                    ovf_d          = 1'b0;
                    last_pending_d = 1'b0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers; reset discards in-flight beats and any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_ACCUM;
            last_pending_q <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            v1_q           <= 1'b0;
            last1_q        <= 1'b0;
            prod_q         <= '0;
            v2_q           <= 1'b0;
            last2_q        <= 1'b0;
            v3_q           <= 1'b0;
            last3_q        <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            out_valid_q    <= 1'b0;
            out_acc_q      <= '0;
            out_cnt_q      <= '0;
            out_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_pending_q <= last_pending_d;
            a_q            <= a_d;
            b_q            <= b_d;
            v1_q           <= v1_d;
            last1_q        <= last1_d;
            prod_q         <= prod_d;
            v2_q           <= v2_d;
            last2_q        <= last2_d;
            v3_q           <= v3_d;
            last3_q        <= last3_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            out_valid_q    <= out_valid_d;
            out_acc_q      <= out_acc_d;
            out_cnt_q      <= out_cnt_d;
            out_ovf_q      <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_dadda_mac.sv
// ---------------------------------------------------------------------------
// tb_dadda_mac
//   Self-checking bench for dadda_mac. The reference keeps a running sum of
//   accepted products and a beat count using plain wide arithmetic; expected
//   out_acc, out_cnt and out_ovf are derived from those at each result.
// ---------------------------------------------------------------------------
module tb_dadda_mac;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    int     assert_cnt = 0;
    int     fail_cnt   = 0;
    longint model_sum  = 0;
    int     model_n    = 0;

    dadda_mac #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_cnt   (out_cnt),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint expAcc();
        return model_sum % (64'd1 << ACC_W);
    endfunction

    function automatic int expCnt();
        return (model_n > 255) ? 255 : model_n;
    endfunction

    function automatic int expOvf();
        return (model_sum >= (64'd1 << ACC_W)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic modelClear();
        model_sum = 0;
        model_n   = 0;
    endtask

    // Offers one pair and waits (bounded) for it to be taken.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 40 && !taken; i++) begin
            taken = in_ready;
            stepCycle();
        end
        checkOutput("accept", 32'(taken), 32'd1);
        if (taken) begin
            model_sum += longint'(a) * longint'(b);
            model_n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expectResult(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) begin
            stepCycle();
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_acc"},   32'(out_acc),   32'(expAcc()));
        checkOutput({tag, "_cnt"},   32'(out_cnt),   32'(expCnt()));
        checkOutput({tag, "_ovf"},   32'(out_ovf),   32'(expOvf()));
    endtask

    // Holds off out_ready for a while, then completes the result handshake.
    task automatic drainResult(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            stepCycle();
            checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, "_hold_acc"},   32'(out_acc),   32'(expAcc()));
            checkOutput({tag, "_hold_cnt"},   32'(out_cnt),   32'(expCnt()));
            checkOutput({tag, "_hold_rdy"},   32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        modelClear();
        checkOutput({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_drain_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_acc",   32'(out_acc),   32'd0);
        checkOutput("rst_out_cnt",   32'(out_cnt),   32'd0);
        checkOutput("rst_out_ovf",   32'(out_ovf),   32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat 255*255 with exact latency
        applyStimulus(8'd255, 8'd255, 1'b1);
        stepCycle();
        checkOutput("t1_valid_T1", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("t1_valid_T2", 32'(out_valid), 32'd0);
        stepCycle();
        checkOutput("t1_valid_T3", 32'(out_valid), 32'd1);
        checkOutput("t1_acc_const", 32'(out_acc), 32'd65025);
        expectResult("t1");
        drainResult("t1", 0);

        // Three beats with a bubble, then a stalled result
        applyStimulus(8'd3, 8'd4, 1'b0);
        stepCycle();
        applyStimulus(8'd5, 8'd6, 1'b0);
        applyStimulus(8'd7, 8'd8, 1'b1);
        expectResult("t2");
        checkOutput("t2_acc_const", 32'(out_acc), 32'd98);
        drainResult("t4", 5);

        // 259 beats of 255*255: wrap, sticky overflow, saturated count
        for (int i = 0; i < 259; i++) begin
            applyStimulus(8'd255, 8'd255, (i == 258));
        end
        expectResult("t3");
        checkOutput("t3_acc_const", 32'(out_acc), 32'd64259);
        checkOutput("t3_cnt_const", 32'(out_cnt), 32'd255);
        drainResult("t3", 1);

        // Reset mid-accumulation discards in-flight beats
        applyStimulus(8'd10, 8'd11, 1'b0);
        applyStimulus(8'd12, 8'd13, 1'b0);
        stepCycle();
        rst = 1'b1;
        stepCycle();
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_acc",   32'(out_acc),   32'd0);
        checkOutput("t5_rst_rdy",   32'(in_ready),  32'd0);
        rst = 1'b0;
        modelClear();
        #1;
        checkOutput("t5_post_rst_rdy", 32'(in_ready), 32'd1);
        applyStimulus(8'd2, 8'd3, 1'b1);
        expectResult("t5");
        checkOutput("t5_acc_const", 32'(out_acc), 32'd6);
        drainResult("t5", 0);

        // in_valid held high after a last beat: blocked until the handshake
        applyStimulus(8'd9, 8'd9, 1'b1);
        in_valid = 1'b1;
        in_a     = 8'd20;
        in_b     = 8'd30;
        in_last  = 1'b1;
        for (int i = 0; i < 8 && !out_valid; i++) begin
            checkOutput("t6_blocked", 32'(in_ready), 32'd0);
            stepCycle();
        end
        expectResult("t6a");
        out_ready = 1'b1;
        stepCycle();
        out_ready = 1'b0;
        modelClear();
        checkOutput("t6_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_rdy_again",   32'(in_ready),  32'd1);
        stepCycle();
        model_sum = 600;
        model_n   = 1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        expectResult("t6b");
        drainResult("t6b", 0);

        // Multiplier corners and random single-beat products
        applyStimulus(8'd0, 8'd0, 1'b1);
        expectResult("m_zero");
        drainResult("m_zero", 0);
        applyStimulus(8'd255, 8'd1, 1'b1);
        expectResult("m_255x1");
        drainResult("m_255x1", 0);
        applyStimulus(8'd170, 8'd85, 1'b1);
        expectResult("m_170x85");
        drainResult("m_170x85", 0);
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, 1'b1);
            expectResult("m_rand");
            drainResult("m_rand", 0);
        end

        // Random multi-beat accumulations with random bubbles and stalls
        for (int r = 0; r < 4; r++) begin
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    stepCycle();
                end
                ra = 8'($urandom);
                rb = 8'($urandom);
                applyStimulus(ra, rb, (i == n - 1));
            end
            expectResult("rand_acc");
            drainResult("rand_acc", int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
